nn_input_sequencer: RTL and testbench
=====================================

// Module: nn_input_sequencer
// PURPOSE
//  Control FSM for the 4-lane neuron input shift register; drives its selector and data_in.
//  - Accepts a byte stream with a valid/ready handshake and shifts N_INPUTS bytes into the register.
//  - Holds the register while the neuron array computes, then feeds neuron outputs back for each further layer.
//  - Flags the final layer result with a valid/ready handshake.
// PARAMETERS
//  DATA_W          8  byte width of the stream and of each neuron lane
//  N_INPUTS        4  bytes loaded per inference (one per shift-register lane)
//  COMPUTE_CYCLES  3  cycles neuron_en stays high per layer; legal range >= 1
//  NUM_LAYERS      2  layers per inference; legal range >= 1
// PORTS
//  clk           in   1                     rising-edge clock
//  rstn          in   1                     asynchronous reset, active-high (1 = reset)
//  start         in   1                     one-cycle pulse that begins an inference; used only in IDLE
//  in_valid      in   1                     upstream byte valid
//  in_data       in   DATA_W                upstream byte
//  in_ready      out  1                     sequencer accepts in_data this cycle
//  sr_data_in    out  DATA_W                to shift register data_in; equals in_data
//  selector      out  2                     to shift register: 00 shift, 01 hold, 10 load feedback
//  neuron_en     out  1                     neuron array compute enable
//  layer_idx     out  clog2(NUM_LAYERS)+1   index of the current layer
//  result_valid  out  1                     shift register lanes hold the final layer result
//  result_ready  in   1                     downstream has consumed the result
//  busy          out  1                     high in every state except IDLE
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-operation):
//  - Clear state, byte counter, cycle counter and layer_idx; state = IDLE.
//  - Output values: selector=01, in_ready=0, neuron_en=0, result_valid=0, busy=0, layer_idx=0.
//  States (registered; outputs decoded combinationally from state, counters and in_valid):
//  IDLE:
//  - selector=01.
//  - start=1 -> LOAD; byte counter=0.
//  LOAD:
//  - in_ready=1.
//  - selector=00 when in_valid=1, else 01, so a shift happens exactly on an accepted beat.
//  - Each accept increments the byte counter.
//  - Accept number N_INPUTS -> COMPUTE; cycle counter=0, layer_idx=0.
//  - Gaps (in_valid=0) are allowed anywhere in the burst; the register holds through them.
//  COMPUTE:
//  - selector=01, neuron_en=1, in_ready=0.
//  - Cycle counter increments each cycle.
//  - At counter = COMPUTE_CYCLES-1: last layer (layer_idx = NUM_LAYERS-1) -> DONE, otherwise -> FEEDBACK.
//  FEEDBACK:
//  - Exactly one cycle: selector=10, neuron_en=0.
//  - -> COMPUTE; layer_idx+1, cycle counter=0.
//  DONE:
//  - selector=01, result_valid=1, held until result_ready=1.
//  - Result accepted on the cycle result_ready=1 -> IDLE.
//  - result_valid never drops without a handshake.
//  Latency:
//  - start edge -> in_ready high on the next cycle.
//  - Last accepted byte -> result_valid high after NUM_LAYERS*COMPUTE_CYCLES + (NUM_LAYERS-1) cycles.
//  - Defaults: 3*2+1 = 7 cycles.
//  Boundary conditions:
//  - start outside IDLE is ignored.
//  - in_valid outside LOAD is ignored; in_ready=0 there.
//  - NUM_LAYERS=1: FEEDBACK is never entered.
//  - COMPUTE_CYCLES=1: neuron_en pulses for one cycle per layer.
//  - Counters never wrap; they are cleared on every state entry that uses them.
//  - selector never takes 11.
//  - start together with result_ready in DONE: the result_ready takes effect and start is dropped; start must be re-issued in IDLE.
// TESTING
//  1. Reset pulse mid-COMPUTE -> asynchronous return to IDLE; all outputs at their reset values the same cycle; layer_idx=0.
//  2. start, then 4 back-to-back beats 0x11,0x22,0x33,0x44 -> selector=00 for 4 cycles; neuron_en high 3 cycles; selector=10 one cycle; neuron_en 3 cycles; result_valid 7 cycles after the last beat.
//  3. Same beats with in_valid low on alternate cycles -> selector alternates 00/01; only 4 shifts occur; COMPUTE entered after the 4th accept.
//  4. result_ready held low 5 cycles in DONE -> result_valid and selector=01 stable; result_ready=1 -> IDLE next cycle, busy=0.
//  5. start pulsed during LOAD and COMPUTE, in_valid=1 during COMPUTE -> no state change, in_ready=0, byte counter unaffected.
//  6. NUM_LAYERS=1, COMPUTE_CYCLES=1 -> no selector=10 cycle; result_valid 1 cycle after the 4th accept.

Source files
------------

// File: rtl/nn_input_sequencer_if.sv
// nn_input_sequencer_if: stream, shift-register control and result handshake bundle for the input sequencer
interface nn_input_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int LW     = 2
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] sr_data_in;
  logic [1:0]        selector;
  logic              neuron_en;
  logic [LW-1:0]     layer_idx;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  modport slave (
    input  start, in_valid, in_data, result_ready,
    output in_ready, sr_data_in, selector, neuron_en, layer_idx, result_valid, busy
  );
  modport master (
    output start, in_valid, in_data, result_ready,
    input  in_ready, sr_data_in, selector, neuron_en, layer_idx, result_valid, busy
  );
endinterface

// File: rtl/nn_input_sequencer.sv
// nn_input_sequencer: loads N_INPUTS bytes into the neuron shift register, then sequences compute/feedback per layer
module nn_input_sequencer #(
  parameter int DATA_W         = 8,
  parameter int N_INPUTS       = 4,
  parameter int COMPUTE_CYCLES = 3,
  parameter int NUM_LAYERS     = 2
) (
  input logic                clk,
  input logic                rstn,
  nn_input_sequencer_if.slave bus
);
  localparam int LW = $clog2(NUM_LAYERS) + 1;
  localparam int BW = $clog2(N_INPUTS + 1);
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FEEDBACK, DONE} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          last_byte, last_cyc, last_layer;
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      byte_q  <= '0;
      cyc_q   <= '0;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cyc_q   <= cyc_d;
      layer_q <= layer_d;
    end
  end
  assign last_byte  = byte_q == BW'(N_INPUTS - 1);
  assign last_cyc   = cyc_q == CW'(COMPUTE_CYCLES - 1);
  assign last_layer = layer_q == LW'(NUM_LAYERS - 1);
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    cyc_d   = cyc_q;
    layer_d = layer_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        byte_d  = '0;
      end
      LOAD: if (bus.in_valid) begin
        byte_d = byte_q + BW'(1);
        if (last_byte) begin
          state_d = COMPUTE;
          cyc_d   = '0;
          layer_d = '0;
        end
      end
      COMPUTE: begin
        cyc_d   = last_cyc ? cyc_q : cyc_q + CW'(1);
        state_d = !last_cyc ? COMPUTE : last_layer ? DONE : FEEDBACK;
      end
      FEEDBACK: begin
        state_d = COMPUTE;
        layer_d = layer_q + LW'(1);
        cyc_d   = '0;
      end
      DONE: state_d = bus.result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // A shift is issued only on an accepted beat so gaps leave the register untouched
  assign bus.selector     = state_q == FEEDBACK ? 2'b10 : (state_q == LOAD && bus.in_valid) ? 2'b00 : 2'b01;
  assign bus.in_ready     = state_q == LOAD;
  assign bus.neuron_en    = state_q == COMPUTE;
  assign bus.result_valid = state_q == DONE;
  assign bus.busy         = state_q != IDLE;
  assign bus.layer_idx    = layer_q;
  assign bus.sr_data_in   = bus.in_data;
  a_sel_legal: assert property (@(posedge clk) disable iff (rstn) bus.selector != 2'b11);
  a_rv_hold: assert property (@(posedge clk) disable iff (rstn) bus.result_valid && !bus.result_ready |=> bus.result_valid);
endmodule

// File: tb/tb_nn_input_sequencer.sv
// tb_nn_input_sequencer: drives two configurations (2 layers x 3 cycles, 1 layer x 1 cycle) against a timeline model
module tb_nn_input_sequencer;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       st = 1'b0, iv = 1'b0, rr = 1'b0;
  logic [7:0] din = 8'h00;
  int         tests = 0, fails = 0;
  int         m_mode[2], m_k[2], m_t[2], m_lay[2];
  int         PL[2] = '{2, 1};
  int         PC[2] = '{3, 1};
  logic [1:0] o_sel[2], o_lay[2];
  logic       o_rdy[2], o_ne[2], o_rv[2], o_bz[2];
  logic [7:0] o_dat[2];
  logic [7:0] bt[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         la, lb;
  always #5 clk = ~clk;
  nn_input_sequencer_if #(.DATA_W(8), .LW(2)) ifa ();
  nn_input_sequencer_if #(.DATA_W(8), .LW(1)) ifb ();
  nn_input_sequencer #(.DATA_W(8), .N_INPUTS(4), .COMPUTE_CYCLES(3), .NUM_LAYERS(2)) ua (.clk(clk), .rstn(rstn), .bus(ifa.slave));
  nn_input_sequencer #(.DATA_W(8), .N_INPUTS(4), .COMPUTE_CYCLES(1), .NUM_LAYERS(1)) ub (.clk(clk), .rstn(rstn), .bus(ifb.slave));
  assign ifa.start = st;
  assign ifa.in_valid = iv;
  assign ifa.in_data = din;
  assign ifa.result_ready = rr;
  assign ifb.start = st;
  assign ifb.in_valid = iv;
  assign ifb.in_data = din;
  assign ifb.result_ready = rr;
  assign o_sel[0] = ifa.selector;
  assign o_sel[1] = ifb.selector;
  assign o_lay[0] = ifa.layer_idx;
  assign o_lay[1] = {1'b0, ifb.layer_idx};
  assign o_rdy[0] = ifa.in_ready;
  assign o_rdy[1] = ifb.in_ready;
  assign o_ne[0] = ifa.neuron_en;
  assign o_ne[1] = ifb.neuron_en;
  assign o_rv[0] = ifa.result_valid;
  assign o_rv[1] = ifb.result_valid;
  assign o_bz[0] = ifa.busy;
  assign o_bz[1] = ifb.busy;
  assign o_dat[0] = ifa.sr_data_in;
  assign o_dat[1] = ifb.sr_data_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected outputs come from elapsed time since the last accepted byte: each layer is C compute cycles plus one feedback slot
  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      int p, tot, es, er, en, ev, eb, el;
      p = PC[i] + 1;
      tot = PL[i] * p - 1;
      el = m_lay[i];
      es = 1; er = 0; en = 0; ev = 0;
      eb = (m_mode[i] != 0) ? 1 : 0;
      if (m_mode[i] == 1) begin
        er = 1;
        es = iv ? 0 : 1;
      end else if (m_mode[i] == 2) begin
        if (m_t[i] < tot) begin
          el = m_t[i] / p;
          if (m_t[i] % p < PC[i]) en = 1; else es = 2;
        end else begin
          el = PL[i] - 1;
          ev = 1;
        end
      end
      chk($sformatf("%s[%0d].selector", tag, i), {30'd0, o_sel[i]}, es);
      chk($sformatf("%s[%0d].in_ready", tag, i), {31'd0, o_rdy[i]}, er);
      chk($sformatf("%s[%0d].neuron_en", tag, i), {31'd0, o_ne[i]}, en);
      chk($sformatf("%s[%0d].result_valid", tag, i), {31'd0, o_rv[i]}, ev);
      chk($sformatf("%s[%0d].busy", tag, i), {31'd0, o_bz[i]}, eb);
      chk($sformatf("%s[%0d].sr_data_in", tag, i), {24'd0, o_dat[i]}, {24'd0, din});
      if (el >= 0) chk($sformatf("%s[%0d].layer_idx", tag, i), {30'd0, o_lay[i]}, el);
    end
  endtask
  task automatic step(input logic s, input logic v, input logic r);
    for (int i = 0; i < 2; i++) begin
      case (m_mode[i])
        0: if (s) begin m_mode[i] = 1; m_k[i] = 0; end
        1: if (v) begin
          m_k[i]++;
          if (m_k[i] == 4) begin m_mode[i] = 2; m_t[i] = 0; m_lay[i] = 0; end
        end
        default: if (m_t[i] < PL[i] * (PC[i] + 1) - 1) m_t[i]++;
          else if (r) begin m_mode[i] = 0; m_lay[i] = -1; end
      endcase
    end
  endtask
  task automatic cyc(input string tag, input logic s, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    st = s; iv = v; din = d; rr = r;
    #1 check_all(tag);
    @(posedge clk);
    step(s, v, r);
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    st = 0; iv = 0; rr = 0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin m_mode[i] = 0; m_lay[i] = 0; end
    #1 check_all(tag);
    @(posedge clk);
    #1 check_all(tag);
    @(negedge clk);
    rstn = 1'b0;
  endtask
  task automatic measure(output int a, output int b);
    a = -1; b = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      st = 0; iv = 0; rr = 0;
      #1 check_all("lat");
      if (a < 0 && o_rv[0]) a = n - 1;
      if (b < 0 && o_rv[1]) b = n - 1;
      @(posedge clk);
      step(0, 0, 0);
    end
  endtask
  initial begin
    do_reset("reset");
    // reset pulse in the middle of COMPUTE
    cyc("t1", 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc("t1", 0, 1, bt[i], 0);
    cyc("t1", 0, 0, 8'h00, 0);
    cyc("t1", 0, 0, 8'h00, 0);
    do_reset("t1_rst");
    // back-to-back beats and end-to-end latency
    cyc("t2", 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc("t2", 0, 1, bt[i], 0);
    measure(la, lb);
    chk("t2.latency_a", la, 7);
    chk("t2.latency_b", lb, 1);
    cyc("t2", 0, 0, 8'h00, 1);
    cyc("t2", 0, 0, 8'h00, 0);
    // gaps on alternate cycles, then ignored start/in_valid while computing
    cyc("t3", 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cyc("t3", 0, ~i[0], bt[i / 2], 0);
    for (int i = 0; i < 3; i++) cyc("t5", 1, 1, 8'($urandom), 0);
    for (int i = 0; i < 4; i++) cyc("t5", 0, 0, 8'h00, 0);
    // result held in DONE, then start coincident with result_ready is dropped
    for (int i = 0; i < 5; i++) cyc("t4", 0, 0, 8'h00, 0);
    cyc("t4", 1, 0, 8'h00, 1);
    cyc("t4", 0, 0, 8'h00, 0);
    cyc("t4", 0, 1, 8'h5a, 0);
    // start repeated inside LOAD must not reset the byte count
    cyc("t5", 1, 0, 8'h00, 0);
    cyc("t5", 0, 1, 8'ha1, 0);
    cyc("t5", 1, 0, 8'h00, 0);
    cyc("t5", 1, 1, 8'ha2, 0);
    cyc("t5", 0, 1, 8'ha3, 0);
    cyc("t5", 1, 1, 8'ha4, 0);
    for (int i = 0; i < 10; i++) cyc("t5", 0, 1, 8'h00, i > 7);
    for (int i = 0; i < 800; i++) begin
      cyc("rnd", ($urandom % 4) == 0, $urandom % 2, 8'($urandom), ($urandom % 3) == 0);
      if (i == 400) do_reset("rnd_rst");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
